// File: rtl/load_store_unit.sv
`default_nettype none
//============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit between the memory pipeline
//               stage and a byte-addressed data memory. Drives 2-bit read/write
//               strobes, absorbs the memory's one-cycle read latency, formats
//               load data (LB/LBU/LW), bounds-checks every access and keeps
//               saturating load/store counters.
// Options     : ALIGN_CHECK_EN - when defined, LW/SW with addr[1:0] != 0
//               fault exactly like out-of-range accesses.
// Revision    : 1.0 - initial release
//============================================================================
module load_store_unit #(
    parameter int MEM_BYTES = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [4:0]       req_rd,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [4:0]       resp_rd,
    output logic             resp_fault,
    output logic             illegal_op,
    output logic [1:0]       mem_read,
    output logic [1:0]       mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_word_in,
    input  logic [31:0]      mem_word_out,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0]       c_STROBE_IDLE = 2'b00;
    localparam logic [1:0]       c_STROBE_BYTE = 2'b01;
    localparam logic [1:0]       c_STROBE_WORD = 2'b11;
    localparam logic [32:0]      c_MEM_LIMIT   = 33'(MEM_BYTES);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_op;
    logic [4:0]  r_rd;

    logic        w_accept;
    logic        w_is_store;
    logic        w_is_word;
    logic        w_legal;
    logic        w_fault;
    logic [32:0] w_last_byte;
    logic [31:0] w_load_fmt;

    logic [1:0]  w_mem_read_nxt;
    logic [1:0]  w_mem_write_nxt;
    logic [31:0] w_mem_address_nxt;
    logic [31:0] w_mem_word_in_nxt;
    logic        w_resp_valid_nxt;
    logic        w_resp_fault_nxt;
    logic [31:0] w_resp_data_nxt;
    logic [4:0]  w_resp_rd_nxt;
    logic        w_illegal_nxt;
    logic        w_load_inc;
    logic        w_store_inc;

    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && (r_state == ST_IDLE);

    // Decode the incoming request; the last-byte address is formed in 33 bits
    // so addresses near 2^32 cannot wrap back into range.
    always_comb begin
        w_is_store  = req_op[2];
        w_is_word   = (req_op[1:0] == 2'b11);
        w_legal     = (req_op[1:0] != 2'b00) && (req_op != 3'b110);
        w_last_byte = {1'b0, req_addr} + (w_is_word ? 33'd3 : 33'd0);
`ifdef ALIGN_CHECK_EN
        w_fault     = (w_last_byte >= c_MEM_LIMIT) ||
                      (w_is_word && (req_addr[1:0] != 2'b00));
`else
        w_fault     = (w_last_byte >= c_MEM_LIMIT);
`endif
    end

    // Sign- or zero-extend the returned memory word according to the latched op.
    always_comb begin
        w_load_fmt = mem_word_out;
        case (r_op[1:0])
            2'b01:   w_load_fmt = {{24{mem_word_out[7]}}, mem_word_out[7:0]};
            2'b10:   w_load_fmt = {24'b0, mem_word_out[7:0]};
            default: w_load_fmt = mem_word_out;
        endcase
    end

    // Next-state and next-output logic; strobes default to idle so they last
    // exactly one cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_mem_read_nxt    = c_STROBE_IDLE;
        w_mem_write_nxt   = c_STROBE_IDLE;
        w_mem_address_nxt = mem_address;
        w_mem_word_in_nxt = mem_word_in;
        w_resp_valid_nxt  = 1'b0;
        w_resp_fault_nxt  = 1'b0;
        w_resp_data_nxt   = resp_data;
        w_resp_rd_nxt     = resp_rd;
        w_illegal_nxt     = 1'b0;
        w_load_inc        = 1'b0;
        w_store_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!w_legal) begin
                        w_illegal_nxt = 1'b1;
                    end else if (w_fault) begin
                        // Faulting stores vanish; faulting loads still answer.
                        if (!w_is_store) begin
                            w_state_nxt      = ST_RESP;
                            w_resp_valid_nxt = 1'b1;
                            w_resp_fault_nxt = 1'b1;
                            w_resp_data_nxt  = 32'd0;
                            w_resp_rd_nxt    = req_rd;
                        end
                    end else begin
                        w_state_nxt       = ST_ISSUE;
                        w_mem_address_nxt = req_addr;
                        w_mem_word_in_nxt = req_wdata;
                        if (w_is_store) begin
                            w_mem_write_nxt = w_is_word ? c_STROBE_WORD : c_STROBE_BYTE;
                        end else begin
                            w_mem_read_nxt  = w_is_word ? c_STROBE_WORD : c_STROBE_BYTE;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (r_op[2]) begin
                    w_store_inc = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_nxt      = ST_RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_data_nxt  = w_load_fmt;
                w_resp_rd_nxt    = r_rd;
                w_load_inc       = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs and request fields captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read    <= c_STROBE_IDLE;
            mem_write   <= c_STROBE_IDLE;
            mem_address <= 32'd0;
            mem_word_in <= 32'd0;
            resp_valid  <= 1'b0;
            resp_fault  <= 1'b0;
            resp_data   <= 32'd0;
            resp_rd     <= 5'd0;
            illegal_op  <= 1'b0;
            r_op        <= 3'd0;
            r_rd        <= 5'd0;
        end else begin
            mem_read    <= w_mem_read_nxt;
            mem_write   <= w_mem_write_nxt;
            mem_address <= w_mem_address_nxt;
            mem_word_in <= w_mem_word_in_nxt;
            resp_valid  <= w_resp_valid_nxt;
            resp_fault  <= w_resp_fault_nxt;
            resp_data   <= w_resp_data_nxt;
            resp_rd     <= w_resp_rd_nxt;
            illegal_op  <= w_illegal_nxt;
            if (w_accept) begin
                r_op <= req_op;
                r_rd <= req_rd;
            end
        end
    end

    // Saturating event counters for completed, non-faulting accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count  <= '0;
            store_count <= '0;
        end else begin
            if (w_load_inc && (load_count != c_CNT_MAX)) begin
                load_count <= load_count + c_CNT_ONE;
            end
            if (w_store_inc && (store_count != c_CNT_MAX)) begin
                store_count <= store_count + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A byte-array memory
//               serves the DUT; a separate reference memory and counter model
//               predict every response from the access rules.
// Options     : ALIGN_CHECK_EN changes the expected unaligned-word behaviour.
// Revision    : 1.0 - initial release
//============================================================================
module tb_load_store_unit;

    localparam int MEM_BYTES = 64;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;

    localparam logic [2:0] OP_LB = 3'b001, OP_LBU = 3'b010, OP_LW = 3'b011;
    localparam logic [2:0] OP_SB = 3'b101, OP_SW  = 3'b111;

    localparam int K_LOAD = 0, K_LFAULT = 1, K_STORE = 2, K_SDROP = 3, K_ILL = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [31:0]      req_addr = '0;
    logic [31:0]      req_wdata = '0;
    logic [4:0]       req_rd = '0;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic [4:0]       resp_rd;
    logic             resp_fault;
    logic             illegal_op;
    logic [1:0]       mem_read;
    logic [1:0]       mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_word_in;
    logic [31:0]      mem_word_out;
    logic [CNT_W-1:0] load_count;
    logic [CNT_W-1:0] store_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem     [0:MEM_BYTES-1];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic        preload = 1'b0;

    int          exp_kind;
    logic [31:0] exp_data;
    int          exp_lcnt = 0;
    int          exp_scnt = 0;

    int          obs_resp_cnt, obs_resp_k, obs_ill_cnt, obs_ill_k;
    logic [31:0] obs_data;
    logic [4:0]  obs_rd;
    logic        obs_fault, obs_ready_k1, obs_ready_k2;
    logic [1:0]  obs_rd_val, obs_wr_val;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_fault(resp_fault), .illegal_op(illegal_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_word_in(mem_word_in), .mem_word_out(mem_word_out),
        .load_count(load_count), .store_count(store_count)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input logic [31:0] a);
        return int'(a % 32'(MEM_BYTES));
    endfunction

    // Data memory: writes and read sampling on the clock edge, big-endian words.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= ref_mem[i];
        end else begin
            if (mem_write == 2'b01) mem[wrap(mem_address)] <= mem_word_in[7:0];
            if (mem_write == 2'b11)
                for (int i = 0; i < 4; i++) mem[wrap(mem_address + 32'(i))] <= mem_word_in[31-8*i -: 8];
            if (mem_read == 2'b01) mem_word_out <= {24'hA5A5A5, mem[wrap(mem_address)]};
            if (mem_read == 2'b11)
                mem_word_out <= {mem[wrap(mem_address)], mem[wrap(mem_address + 32'd1)],
                                 mem[wrap(mem_address + 32'd2)], mem[wrap(mem_address + 32'd3)]};
        end
    end

    // Strobe exclusivity watched on every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (mem_read != 2'b00 && mem_write != 2'b00) begin
                errors++;
                $display("FAIL strobe_exclusive: mem_read=%b mem_write=%b want one idle", mem_read, mem_write);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: classify the access and update the expected memory/counters.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        longint a;
        int     size;
        bit     legal, bad;
        logic [7:0] b;
        a     = longint'({32'h0, addr});
        size  = (op == OP_LW || op == OP_SW) ? 4 : 1;
        legal = (op inside {OP_LB, OP_LBU, OP_LW, OP_SB, OP_SW});
        bad   = (a + size > MEM_BYTES);
`ifdef ALIGN_CHECK_EN
        if (size == 4 && (a % 4) != 0) bad = 1'b1;
`endif
        exp_data = 32'd0;
        if (!legal) begin
            exp_kind = K_ILL;
        end else if (bad) begin
            exp_kind = op[2] ? K_SDROP : K_LFAULT;
        end else if (op[2]) begin
            exp_kind = K_STORE;
            for (int i = 0; i < size; i++)
                ref_mem[int'(a) + i] = (size == 4) ? wdata[31-8*i -: 8] : wdata[7:0];
            if (exp_scnt < CNT_MAX) exp_scnt++;
        end else begin
            exp_kind = K_LOAD;
            b = ref_mem[int'(a)];
            if (size == 4)
                exp_data = {ref_mem[int'(a)], ref_mem[int'(a)+1], ref_mem[int'(a)+2], ref_mem[int'(a)+3]};
            else if (op == OP_LB)
                exp_data = (b >= 8'd128) ? (32'(b) - 32'd256) : 32'(b);
            else
                exp_data = 32'(b);
            if (exp_lcnt < CNT_MAX) exp_lcnt++;
        end
    endtask

    // Present one request, then observe five cycles after the acceptance edge.
    task automatic send(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd);
        int guard = 0;
        model(op, addr, wdata);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b want 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        obs_resp_cnt = 0; obs_resp_k = 0; obs_ill_cnt = 0; obs_ill_k = 0;
        obs_data = '0; obs_rd = '0; obs_fault = 1'b0; obs_rd_val = '0; obs_wr_val = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (obs_resp_cnt == 0) begin
                    obs_resp_k = k; obs_data = resp_data; obs_rd = resp_rd; obs_fault = resp_fault;
                end
                obs_resp_cnt++;
            end
            if (illegal_op === 1'b1) begin obs_ill_cnt++; obs_ill_k = k; end
            obs_rd_val |= mem_read;
            obs_wr_val |= mem_write;
            if (k == 1) obs_ready_k1 = req_ready;
            if (k == 2) obs_ready_k2 = req_ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_fault, illegal_op, mem_read, mem_write} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10000000",
                     {req_ready, resp_valid, resp_fault, illegal_op, mem_read, mem_write});
        end
        checks++;
        if ({resp_data, resp_rd, mem_address, mem_word_in} !== 101'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {resp_data, resp_rd, mem_address, mem_word_in});
        end
        checks++;
        if ({load_count, store_count} !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: got %h want 0", {load_count, store_count});
        end
        @(negedge clk);
        preload = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b resp_valid=%b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_directed();
        send(OP_SW, 32'd8, 32'h80112233, 5'd0);
        checks++;
        if (obs_wr_val !== 2'b11 || obs_rd_val !== 2'b00) begin
            errors++; $display("FAIL sw_strobe: wr=%b rd=%b want 11 00", obs_wr_val, obs_rd_val);
        end
        checks++;
        if ({obs_ready_k1, obs_ready_k2} !== 2'b01) begin
            errors++; $display("FAIL sw_ready: got %b want 01", {obs_ready_k1, obs_ready_k2});
        end
        checks++;
        if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h80112233) begin
            errors++; $display("FAIL sw_mem: got %h want 80112233", {mem[8], mem[9], mem[10], mem[11]});
        end
        send(OP_LW, 32'd8, 32'd0, 5'd5);
        checks++;
        if (obs_resp_cnt !== 1 || obs_resp_k !== 3) begin
            errors++; $display("FAIL lw_latency: pulses=%0d cycle=%0d want 1 3", obs_resp_cnt, obs_resp_k);
        end
        checks++;
        if ({obs_data, obs_rd, obs_fault} !== {32'h80112233, 5'd5, 1'b0}) begin
            errors++; $display("FAIL lw_resp: data=%h rd=%0d fault=%b want 80112233 5 0", obs_data, obs_rd, obs_fault);
        end
        checks++;
        if (load_count !== 4'd1 || store_count !== 4'd1) begin
            errors++; $display("FAIL lw_counts: load=%0d store=%0d want 1 1", load_count, store_count);
        end
        send(OP_SB, 32'd3, 32'h000000F0, 5'd0);
        checks++;
        if (mem[3] !== 8'hF0 || obs_wr_val !== 2'b01) begin
            errors++; $display("FAIL sb: mem3=%h wr=%b want f0 01", mem[3], obs_wr_val);
        end
        send(OP_LB, 32'd3, 32'd0, 5'd1);
        checks++;
        if (obs_data !== 32'hFFFFFFF0 || obs_rd_val !== 2'b01) begin
            errors++; $display("FAIL lb: data=%h rd=%b want fffffff0 01", obs_data, obs_rd_val);
        end
        send(OP_LBU, 32'd3, 32'd0, 5'd2);
        checks++;
        if (obs_data !== 32'h000000F0 || obs_rd !== 5'd2) begin
            errors++; $display("FAIL lbu: data=%h rd=%0d want 000000f0 2", obs_data, obs_rd);
        end
    endtask

    task automatic test_fault();
        send(OP_LW, 32'd61, 32'd0, 5'd12);
        checks++;
        if ({obs_resp_k, obs_fault, obs_data, obs_rd} !== {32'd1, 1'b1, 32'd0, 5'd12}) begin
            errors++; $display("FAIL lw61_fault: cycle=%0d fault=%b data=%h rd=%0d want 1 1 0 12",
                               obs_resp_k, obs_fault, obs_data, obs_rd);
        end
        checks++;
        if (obs_rd_val !== 2'b00 || load_count !== 4'(exp_lcnt)) begin
            errors++; $display("FAIL lw61_side: rd=%b load=%0d want 00 %0d", obs_rd_val, load_count, exp_lcnt);
        end
        send(OP_SW, 32'hFFFFFFFD, 32'h12345678, 5'd0);
        checks++;
        if (obs_wr_val !== 2'b00 || obs_resp_cnt !== 0 || store_count !== 4'(exp_scnt)) begin
            errors++; $display("FAIL sw_wrap: wr=%b resp=%0d store=%0d want 00 0 %0d",
                               obs_wr_val, obs_resp_cnt, store_count, exp_scnt);
        end
        send(OP_LB, 32'd64, 32'd0, 5'd3);
        checks++;
        if (obs_fault !== 1'b1 || obs_resp_k !== 1) begin
            errors++; $display("FAIL lb64: fault=%b cycle=%0d want 1 1", obs_fault, obs_resp_k);
        end
        send(OP_LBU, 32'd63, 32'd0, 5'd4);
        checks++;
        if (obs_fault !== 1'b0 || obs_data !== exp_data) begin
            errors++; $display("FAIL lbu63: fault=%b data=%h want 0 %h", obs_fault, obs_data, exp_data);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ops [3] = '{3'b100, 3'b000, 3'b110};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], 32'd4, 32'hDEADBEEF, 5'd6);
            checks++;
            if (obs_ill_cnt !== 1 || obs_ill_k !== 1 || obs_ready_k1 !== 1'b1) begin
                errors++; $display("FAIL illegal_%b: pulses=%0d cycle=%0d ready=%b want 1 1 1",
                                   ops[i], obs_ill_cnt, obs_ill_k, obs_ready_k1);
            end
            checks++;
            if ({obs_rd_val, obs_wr_val} !== 4'b0000 || obs_resp_cnt !== 0) begin
                errors++; $display("FAIL illegal_side_%b: strobes=%b resp=%0d want 0000 0",
                                   ops[i], {obs_rd_val, obs_wr_val}, obs_resp_cnt);
            end
        end
    endtask

    task automatic test_unaligned();
        send(OP_SW, 32'd0, 32'hAABBCCDD, 5'd0);
        send(OP_SW, 32'd4, 32'h11223344, 5'd0);
        send(OP_LW, 32'd2, 32'd0, 5'd3);
        checks++;
`ifdef ALIGN_CHECK_EN
        if ({obs_fault, obs_data, obs_rd_val} !== {1'b1, 32'd0, 2'b00}) begin
            errors++; $display("FAIL lw_unaligned: fault=%b data=%h rd=%b want 1 0 00", obs_fault, obs_data, obs_rd_val);
        end
`else
        if ({obs_fault, obs_data, obs_resp_k} !== {1'b0, 32'hCCDD1122, 32'd3}) begin
            errors++; $display("FAIL lw_unaligned: fault=%b data=%h cycle=%0d want 0 ccdd1122 3",
                               obs_fault, obs_data, obs_resp_k);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int          resp_k = 0;
        logic [31:0] rdata = '0;
        logic        rdy1 = 1'b0, rdy2 = 1'b0;
        d = $urandom;
        model(OP_SW, 32'd20, d);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'd20; req_wdata = d; req_rd = 5'd0;
        @(posedge clk);
        #1;
        model(OP_LW, 32'd20, 32'd0);
        req_op = OP_LW; req_rd = 5'd9;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) rdy1 = req_ready;
            if (k == 2) rdy2 = req_ready;
            if (k == 3) req_valid = 1'b0;
            if (resp_valid === 1'b1 && resp_k == 0) begin resp_k = k; rdata = resp_data; end
        end
        checks++;
        if ({rdy1, rdy2} !== 2'b01 || resp_k !== 5) begin
            errors++; $display("FAIL b2b_timing: ready=%b cycle=%0d want 01 5", {rdy1, rdy2}, resp_k);
        end
        checks++;
        if (rdata !== exp_data) begin
            errors++; $display("FAIL b2b_data: got %h want %h", rdata, exp_data);
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [1:0]  enc;
        for (int n = 0; n < 60; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES + 3));
            rd   = 5'($urandom);
            send(op, addr, $urandom, rd);
            enc = (op[1:0] == 2'b11) ? 2'b11 : 2'b01;
            checks++;
            if (obs_rd_val !== ((exp_kind == K_LOAD) ? enc : 2'b00) ||
                obs_wr_val !== ((exp_kind == K_STORE) ? enc : 2'b00)) begin
                errors++; $display("FAIL rnd_strobe op=%b addr=%h: rd=%b wr=%b kind=%0d",
                                   op, addr, obs_rd_val, obs_wr_val, exp_kind);
            end
            checks++;
            if (obs_resp_cnt !== ((exp_kind == K_LOAD || exp_kind == K_LFAULT) ? 1 : 0) ||
                obs_ill_cnt !== ((exp_kind == K_ILL) ? 1 : 0)) begin
                errors++; $display("FAIL rnd_pulses op=%b addr=%h: resp=%0d ill=%0d kind=%0d",
                                   op, addr, obs_resp_cnt, obs_ill_cnt, exp_kind);
            end
            if (exp_kind == K_LOAD || exp_kind == K_LFAULT) begin
                checks++;
                if ({obs_data, obs_rd, obs_fault} !== {exp_data, rd, (exp_kind == K_LFAULT)} ||
                    obs_resp_k !== ((exp_kind == K_LOAD) ? 3 : 1)) begin
                    errors++; $display("FAIL rnd_resp op=%b addr=%h: data=%h rd=%0d fault=%b cycle=%0d want %h %0d kind=%0d",
                                       op, addr, obs_data, obs_rd, obs_fault, obs_resp_k, exp_data, rd, exp_kind);
                end
            end
            checks++;
            if (load_count !== 4'(exp_lcnt) || store_count !== 4'(exp_scnt)) begin
                errors++; $display("FAIL rnd_counts: load=%0d store=%0d want %0d %0d",
                                   load_count, store_count, exp_lcnt, exp_scnt);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) begin
            send(OP_SB, 32'd10, 32'(i), 5'd0);
            send(OP_LB, 32'd10, 32'd0, 5'd1);
        end
        checks++;
        if (load_count !== 4'd15 || store_count !== 4'd15) begin
            errors++; $display("FAIL saturation: load=%0d store=%0d want 15 15", load_count, store_count);
        end
    endtask

    task automatic test_reset_midflight();
        int late = 0;
        // Reset while the load waits for memory data.
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'd8; req_rd = 5'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_valid, mem_read, mem_write, req_ready, load_count, store_count} !== {6'b000001, 8'd0}) begin
            errors++; $display("FAIL rst_wait: valid=%b rd=%b wr=%b ready=%b load=%0d store=%0d want 0 00 00 1 0 0",
                               resp_valid, mem_read, mem_write, req_ready, load_count, store_count);
        end
        exp_lcnt = 0; exp_scnt = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid === 1'b1) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++; $display("FAIL rst_wait_resp: got %0d responses want 0", late);
        end
        // Reset while the read strobe is on the bus.
        send(OP_SW, 32'd12, $urandom, 5'd0);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'd12; req_rd = 5'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 2'b11) begin
            errors++; $display("FAIL rst_issue_pre: mem_read=%b want 11", mem_read);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_read !== 2'b00 || store_count !== 4'd0) begin
            errors++; $display("FAIL rst_issue: mem_read=%b store=%0d want 00 0", mem_read, store_count);
        end
        exp_lcnt = 0; exp_scnt = 0;
        @(negedge clk);
        rst = 1'b0;
        late = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid === 1'b1) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++; $display("FAIL rst_issue_resp: got %0d responses want 0", late);
        end
        send(OP_LW, 32'd12, 32'd0, 5'd4);
        checks++;
        if (obs_data !== exp_data || load_count !== 4'd1) begin
            errors++; $display("FAIL post_reset_lw: data=%h load=%0d want %h 1", obs_data, load_count, exp_data);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        test_reset();
        test_directed();
        test_fault();
        test_illegal();
        test_unaligned();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute/memory pipeline stage and the byte-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake and drives the memory's 2-bit mem_read/mem_write encodings. It absorbs the memory's clocked read latency.
- Formats load results (sign/zero extension) and returns them with the destination register tag.
- Performs bounds checking and keeps saturating load/store event counters.

Parameters:
- MEM_BYTES, 64, size of the attached data memory in bytes; accesses beyond it fault.
- CNT_W, 16, width of the load_count and store_count counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_op  input  3  001 LB, 010 LBU, 011 LW, 101 SB, 111 SW; all other codes are illegal.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; SB uses bits [7:0].
- req_rd  input  5  destination register tag for loads.
- resp_valid  output  1  one-cycle pulse carrying a load result or a fault.
- resp_data  output  32  formatted load data; 0 on fault.
- resp_rd  output  5  tag of the responding load.
- resp_fault  output  1  qualifies resp_valid: access faulted, no memory access was made.
- illegal_op  output  1  one-cycle pulse when an illegal opcode is accepted.
- mem_read  output  2  to memory: 00 idle, 01 byte, 11 word.
- mem_write  output  2  to memory: 00 idle, 01 byte, 11 word.
- mem_address  output  32  to memory.
- mem_word_in  output  32  store data to memory.
- mem_word_out  input  32  read data from memory; valid on the edge after the memory samples a read.
- load_count  output  CNT_W  completed non-faulting loads, saturating.
- store_count  output  CNT_W  completed non-faulting stores, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - All outputs clear to 0, except req_ready, which is 1.
  - Counters clear to 0.
  - A request in flight is dropped with no response; memory strobes drop to 00 without waiting for a clock edge.
- All memory-side outputs are registered.
- Invariant: mem_read and mem_write are never both nonzero.
- req_ready = (state == IDLE). A request is accepted on a rising edge with req_valid && req_ready; op, addr, wdata and rd are latched at acceptance.
- IDLE (accept):
  - Legal, in-range op: drive the memory encoding (LB/LBU: read 01; LW: read 11; SB: write 01; SW: write 11), with mem_address = addr and mem_word_in = wdata. Go to ISSUE.
  - Out of range (byte op: addr >= MEM_BYTES; word op: addr > MEM_BYTES-4, with the compare done in 33 bits so 0xFFFFFFFD wraps to fault): no strobe.
    - Load: go to RESP with resp_fault=1 and resp_data=0.
    - Store: drop silently and stay in IDLE.
  - Illegal op: pulse illegal_op for the cycle after acceptance, no strobe, stay in IDLE.
- ISSUE (one cycle): the memory samples the strobes on the closing edge.
  - Strobes return to 00 on that edge.
  - Load goes to WAIT.
  - Store increments store_count and goes to IDLE.
- WAIT: on the closing edge, capture mem_word_out and go to RESP.
  - LB: resp_data = {{24{w[7]}}, w[7:0]}.
  - LBU: resp_data = {24'b0, w[7:0]}.
  - LW: resp_data = w.
  - load_count increments.
- RESP: resp_valid=1 for exactly one cycle, with resp_rd = latched rd. Returns to IDLE on the closing edge.
- Latency, with E0 = acceptance edge:
  - Load: resp_valid high in the cycle after E2.
  - Store: memory written at E1; req_ready high again after E1.
  - Faulting load: resp_valid in the cycle after E0.
- Counters saturate at all-ones. Faulting and illegal ops do not count.
- Back-to-back: a store followed by a load to the same address returns the newly stored data, because the write at E1 precedes the read sampled at E1+2.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: an LW/SW with addr[1:0] != 0 faults with the same behaviour as out-of-range (load gives a fault response, store is dropped, no strobe).
- Undefined: unaligned word accesses proceed; the memory assembles bytes addr..addr+3, MSB first.

Test Plan:
- SW addr=8 wdata=0x80112233, then LW addr=8 rd=5 -> after SW, memory bytes 8..11 = 80,11,22,33. LW gives resp_valid 2 cycles after acceptance, resp_data=0x80112233, resp_rd=5, load_count=1, store_count=1.
- SB addr=3 wdata=0x000000F0, then LB addr=3 and LBU addr=3 -> resp_data 0xFFFFFFF0, then 0x000000F0.
- LW addr=61 with MEM_BYTES=64 -> resp_fault=1, resp_data=0, no mem_read strobe ever asserted. SW addr=0xFFFFFFFD -> no mem_write strobe, store_count unchanged.
- req_op=100 -> illegal_op pulses once, no strobes, req_ready returns high next cycle.
- Assert rst while in WAIT after an LW -> strobes and resp_valid go 0 immediately, no response after reset release, req_ready=1, counters=0.
- With ALIGN_CHECK_EN: LW addr=2 -> fault response. Without it: LW addr=2 after SW addr=0 of 0xAABBCCDD and SW addr=4 of 0x11223344 -> 0xCCDD1122.
